// File: rtl/fb_pkg.sv
// Shared constants and types for the ping-pong frame buffer.
// Defines the default word width, bank depth and the bank-index type.
package fb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 768;

  typedef logic bank_idx_t;

endpackage

// File: rtl/fb_bank_ram.sv
// Single bank: one write port, one registered read port (block-RAM style).
// Ports: clk, we/wr_addr/wr_data (write), re/rd_addr/rd_data (registered read).
module fb_bank_ram
  import fb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // No reset here so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Two-bank frame buffer: writer fills one bank while display reads the other.
// Ports: clk, rst, frame_start, wr_*, wr_frame_done, rd_addr/rd_data, status.
module pingpong_frame_buffer
  import fb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_bank,
  output logic              pending,
  output logic              dropped_frame,
  output logic              repeat_frame,
  output logic [15:0]       swap_count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  bank_idx_t   rd_bank_q, rd_bank_d;
  bank_idx_t   rd_sel_q, rd_sel_d;
  logic        pending_q, pending_d;
  logic        dropped_q, dropped_d;
  logic        repeat_q, repeat_d;
  logic        rd_zero_q, rd_zero_d;
  logic [15:0] swap_cnt_q, swap_cnt_d;

  logic wr_ok, rd_ok, swap;
  logic [1:0] we, re;
  logic [DATA_W-1:0] bank_rd [2];

  assign wr_ok = wr_en & ~rst & ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH_L);
  assign swap  = frame_start & pending_q;

  // Write bank is always the one not on display; this keeps the
  // two ports on distinct banks every cycle, including the swap cycle.
  always_comb begin
    we    = '0;
    re    = '0;
    we[0] = wr_ok & (rd_bank_q == 1'b1);
    we[1] = wr_ok & (rd_bank_q == 1'b0);
    re[0] = rd_ok & (rd_bank_q == 1'b0);
    re[1] = rd_ok & (rd_bank_q == 1'b1);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank_ram #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk    (clk),
      .we     (we[b]),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .re     (re[b]),
      .rd_addr(rd_addr),
      .rd_data(bank_rd[b])
    );
  end

  always_comb begin
    rd_bank_d  = rd_bank_q;
    pending_d  = pending_q;
    swap_cnt_d = swap_cnt_q;
    // Read mux follows the bank that was sampled with the address.
    rd_sel_d   = rd_bank_q;
    rd_zero_d  = ~rd_ok;
    dropped_d  = wr_frame_done & pending_q;
    repeat_d   = frame_start & ~pending_q & ~wr_frame_done;
    if (swap) begin
      rd_bank_d  = ~rd_bank_q;
      pending_d  = 1'b0;
      swap_cnt_d = swap_cnt_q + 16'd1;
    end else if (wr_frame_done) begin
      pending_d  = 1'b1;
    end
    if (rst) begin
      rd_bank_d  = 1'b0;
      pending_d  = 1'b0;
      swap_cnt_d = '0;
      rd_sel_d   = 1'b0;
      rd_zero_d  = 1'b1;
      dropped_d  = 1'b0;
      repeat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    rd_bank_q  <= rd_bank_d;
    rd_sel_q   <= rd_sel_d;
    pending_q  <= pending_d;
    dropped_q  <= dropped_d;
    repeat_q   <= repeat_d;
    rd_zero_q  <= rd_zero_d;
    swap_cnt_q <= swap_cnt_d;
  end

  assign rd_data       = rd_zero_q ? '0 : bank_rd[rd_sel_q];
  assign rd_bank       = rd_bank_q;
  assign pending       = pending_q;
  assign dropped_frame = dropped_q;
  assign repeat_frame  = repeat_q;
  assign swap_count    = swap_cnt_q;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for pingpong_frame_buffer.
// Drives #1 after the rising edge and checks registered outputs there.
module tb_pingpong_frame_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 768;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_bank;
  logic              pending;
  logic              dropped_frame;
  logic              repeat_frame;
  logic [15:0]       swap_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pingpong_frame_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_frame_done(wr_frame_done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_bank      (rd_bank),
    .pending      (pending),
    .dropped_frame(dropped_frame),
    .repeat_frame (repeat_frame),
    .swap_count   (swap_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    frame_start   = 1'b0;
    wr_frame_done = 1'b0;
    wr_en         = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] exp);
    rd_addr = a;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bank"}, 32'(rd_bank), 0);
    chk({tag, "_pend"}, 32'(pending), 0);
    chk({tag, "_rdat"}, 32'(rd_data), 0);
    chk({tag, "_drop"}, 32'(dropped_frame), 0);
    chk({tag, "_rep"}, 32'(repeat_frame), 0);
    chk({tag, "_cnt"}, 32'(swap_count), 0);
  endtask

  initial begin
    rst = 1'b1; idle();
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(); tick();
    chk_reset("rst0");
    rst = 1'b0;
    tick();

    // repeat with nothing pending
    frame_start = 1'b1; tick(); idle();
    chk("rep_pulse", 32'(repeat_frame), 1);
    chk("rep_bank", 32'(rd_bank), 0);
    tick();
    chk("rep_once", 32'(repeat_frame), 0);

    // fill bank 1, including an out-of-range write
    wr(10'd0, 8'h33);
    wr(10'd5, 8'hAA);
    wr(10'd6, 8'h11);
    wr(10'd768, 8'hFF);
    wr_frame_done = 1'b1; tick(); idle();
    chk("done_pend", 32'(pending), 1);
    chk("done_drop", 32'(dropped_frame), 0);
    frame_start = 1'b1; tick(); idle();
    chk("swap1_bank", 32'(rd_bank), 1);
    chk("swap1_cnt", 32'(swap_count), 1);
    chk("swap1_pend", 32'(pending), 0);
    chk("swap1_rep", 32'(repeat_frame), 0);
    rd("rd_aa", 10'd5, 8'hAA);

    // writes now go to bank 0 and must not disturb the display bank
    wr(10'd5, 8'h55);
    wr(10'd7, 8'h77);
    rd("rd_aa_keep", 10'd5, 8'hAA);
    rd("rd_11", 10'd6, 8'h11);
    rd("rd_oob_nowr", 10'd0, 8'h33);
    rd("rd_oob", 10'd768, 8'h00);

    // two completions before frame_start
    wr_frame_done = 1'b1; tick();
    chk("dd_pend1", 32'(pending), 1);
    chk("dd_drop1", 32'(dropped_frame), 0);
    tick(); idle();
    chk("dd_drop2", 32'(dropped_frame), 1);
    chk("dd_pend2", 32'(pending), 1);
    chk("dd_bank2", 32'(rd_bank), 1);
    tick();
    chk("dd_drop_off", 32'(dropped_frame), 0);

    // swap cycle: read and write use pre-swap banks
    frame_start = 1'b1; rd_addr = 10'd6;
    wr_en = 1'b1; wr_addr = 10'd9; wr_data = 8'h99;
    tick(); idle();
    chk("sw2_rd_pre", 32'(rd_data), 32'h11);
    chk("sw2_bank", 32'(rd_bank), 0);
    chk("sw2_cnt", 32'(swap_count), 2);
    rd("rd_55", 10'd5, 8'h55);
    rd("rd_99", 10'd9, 8'h99);

    // simultaneous frame_start and completion, nothing pending
    frame_start = 1'b1; wr_frame_done = 1'b1; tick(); idle();
    chk("sim0_bank", 32'(rd_bank), 0);
    chk("sim0_pend", 32'(pending), 1);
    chk("sim0_rep", 32'(repeat_frame), 0);
    chk("sim0_cnt", 32'(swap_count), 2);
    frame_start = 1'b1; tick(); idle();
    chk("sim0_sw_bank", 32'(rd_bank), 1);
    chk("sim0_sw_cnt", 32'(swap_count), 3);

    // reset with pending=1, swap_count=3
    wr(10'd20, 8'hC3);
    wr_frame_done = 1'b1; tick(); idle();
    chk("pre_rst_pend", 32'(pending), 1);
    chk("pre_rst_cnt", 32'(swap_count), 3);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hEE;
    tick(); tick();
    idle();
    chk_reset("rst1");
    rst = 1'b0;
    tick();
    rd("rd_c3_kept", 10'd20, 8'hC3);
    frame_start = 1'b1; tick(); idle();
    chk("post_rst_rep", 32'(repeat_frame), 1);
    chk("post_rst_bank", 32'(rd_bank), 0);
    wr_frame_done = 1'b1; tick(); idle();
    frame_start = 1'b1; tick(); idle();
    chk("post_rst_sw", 32'(rd_bank), 1);
    chk("post_rst_cnt", 32'(swap_count), 1);
    rd("rd_aa_rstwr", 10'd5, 8'hAA);

    // simultaneous frame_start and completion with pending=1
    wr_frame_done = 1'b1; tick(); idle();
    frame_start = 1'b1; wr_frame_done = 1'b1; tick(); idle();
    chk("sim1_bank", 32'(rd_bank), 0);
    chk("sim1_pend", 32'(pending), 0);
    chk("sim1_drop", 32'(dropped_frame), 1);
    chk("sim1_cnt", 32'(swap_count), 2);
    rd("rd_c3_swap", 10'd20, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
